// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the display scan path.
//   scan_state_e   - scan phase (GAP: all digits dark, SHOW: one digit lit)
//   CODE_W_DEFAULT - default digit code width fed to the segment decoder
//   CODE_DASH/DOT  - special codes understood by the downstream decoder
//   max3           - helper for sizing counters from several limits
package display_pkg;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

  localparam int unsigned CODE_W_DEFAULT = 4;

  localparam logic [3:0] CODE_DASH = 4'b1010;
  localparam logic [3:0] CODE_DOT  = 4'b1011;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// scan_timer: digit scan sequencer for display_scan_mux.
// Alternates a blanking gap (BLANK_CYCLES) and a lit slot (PRESCALE) per
// digit, stepping the digit index at the end of each lit slot.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset (-> GAP, idx 0, cnt 0)
//   show_o       out 1 while the current digit is lit
//   idx_o        out current digit index
//   enter_show_o out 1 when the coming edge moves into a lit slot
//   idx_next_o   out digit index after the coming edge
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             show_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             enter_show_o,
  output logic [IDX_W-1:0] idx_next_o
);

  localparam int unsigned CNT_W     = $clog2(max3(PRESCALE, BLANK_CYCLES, 2));
  localparam int unsigned SHOW_LAST = PRESCALE - 1;
  localparam int unsigned GAP_LAST  = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned IDX_LAST  = NUM_DIGITS - 1;

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             enter_show;
  logic             gap_last, show_last;

  // With no blanking gap the GAP state is only ever seen right after reset,
  // and it must hand over to SHOW on the very first edge.
  assign gap_last  = (BLANK_CYCLES == 0) || (cnt_q == CNT_W'(GAP_LAST));
  assign show_last = (cnt_q == CNT_W'(SHOW_LAST));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 1'b1;
    enter_show = 1'b0;
    case (state_q)
      GAP: begin
        if (gap_last) begin
          cnt_d      = '0;
          state_d    = SHOW;
          enter_show = 1'b1;
        end
      end
      SHOW: begin
        if (show_last) begin
          cnt_d = '0;
          idx_d = (idx_q == IDX_W'(IDX_LAST)) ? '0 : idx_q + 1'b1;
          // Without a gap, moving to the next digit is itself a SHOW entry.
          if (BLANK_CYCLES == 0) enter_show = 1'b1;
          else                   state_d    = GAP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign show_o       = (state_q == SHOW);
  assign idx_o        = idx_q;
  assign enter_show_o = enter_show;
  assign idx_next_o   = idx_d;

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes NUM_DIGITS digit codes onto one
// segment-decoder input with active-low common digit enables. New values
// land in a shadow register and are applied only at a frame boundary.
// Ports:
//   clk          in  system clock
//   rst          in  synchronous active-high reset
//   load         in  capture digits_in/blank_in/dp_in into the shadow
//   digits_in    in  digit i = [i*CODE_W +: CODE_W], digit 0 rightmost
//   blank_in     in  1 = digit i stays dark
//   dp_in        in  1 = decimal point of digit i lit
//   digit_code   out code of the current digit
//   digit_sel_n  out active-low one-hot digit enable
//   dp_n         out active-low decimal point of the current digit
//   pending      out shadow holds a value not yet applied
//   frame_start  out one-cycle pulse when digit 0 lights at frame start
module display_scan_mux
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CODE_W       = CODE_W_DEFAULT,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [NUM_DIGITS*CODE_W-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]        blank_in,
  input  logic [NUM_DIGITS-1:0]        dp_in,
  output logic [CODE_W-1:0]            digit_code,
  output logic [NUM_DIGITS-1:0]        digit_sel_n,
  output logic                         dp_n,
  output logic                         pending,
  output logic                         frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                         show;
  logic [IDX_W-1:0]             idx;
  logic                         enter_show;
  logic [IDX_W-1:0]             idx_next;
  logic                         frame_edge;

  logic [NUM_DIGITS*CODE_W-1:0] shadow_digits_q, active_digits_q;
  logic [NUM_DIGITS-1:0]        shadow_blank_q,  active_blank_q;
  logic [NUM_DIGITS-1:0]        shadow_dp_q,     active_dp_q;
  logic                         pending_q;
  logic                         frame_start_q;

  logic                         lit;

  scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .show_o       (show),
    .idx_o        (idx),
    .enter_show_o (enter_show),
    .idx_next_o   (idx_next)
  );

  assign frame_edge = enter_show && (idx_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digits_q <= '0;
      shadow_blank_q  <= '0;
      shadow_dp_q     <= '0;
      active_digits_q <= '0;
      active_blank_q  <= '0;
      active_dp_q     <= '0;
      pending_q       <= 1'b0;
      frame_start_q   <= 1'b0;
    end else begin
      frame_start_q <= frame_edge;
      if (frame_edge && pending_q) begin
        active_digits_q <= shadow_digits_q;
        active_blank_q  <= shadow_blank_q;
        active_dp_q     <= shadow_dp_q;
        pending_q       <= 1'b0;
      end
      // A load on the boundary edge overrides the clear above: the old
      // shadow is applied and the new value waits for the next frame.
      if (load) begin
        shadow_digits_q <= digits_in;
        shadow_blank_q  <= blank_in;
        shadow_dp_q     <= dp_in;
        pending_q       <= 1'b1;
      end
    end
  end

  always_comb begin
    lit         = show && !active_blank_q[idx];
    digit_code  = active_digits_q[idx*CODE_W +: CODE_W];
    digit_sel_n = '1;
    if (lit) digit_sel_n[idx] = 1'b0;
    dp_n        = ~(lit && active_dp_q[idx]);
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (4 digits, PRESCALE 4, BLANK 2).
// Each cycle the expected outputs are derived from the cycle number within
// the current reset episode and the list of loads, then queued; a monitor
// on the falling edge pops and compares them.
module tb_display_scan_mux;

  localparam int unsigned ND    = 4;
  localparam int unsigned CW    = 4;
  localparam int          PS    = 4;
  localparam int          BL    = 2;
  localparam int          SLOT  = PS + BL;
  localparam int          FRAME = ND * SLOT;
  localparam int          NCYC  = 162;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   digits_in;
  logic [3:0]    blank_in;
  logic [3:0]    dp_in;
  logic [3:0]    digit_code;
  logic [3:0]    digit_sel_n;
  logic          dp_n;
  logic          pending;
  logic          frame_start;

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS   (ND),
    .CODE_W       (CW),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .blank_in    (blank_in),
    .dp_in       (dp_in),
    .digit_code  (digit_code),
    .digit_sel_n (digit_sel_n),
    .dp_n        (dp_n),
    .pending     (pending),
    .frame_start (frame_start)
  );

  typedef struct {
    int          c;
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  p;
  } load_t;

  typedef struct {
    logic [3:0] sel;
    logic       dp_n;
    logic [3:0] code;
    logic       pend;
    logic       fs;
  } exp_t;

  load_t loads[$];
  exp_t  sb[$];
  exp_t  cur_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs for cycle t of the current episode (t=0 is the first
  // cycle after the last reset edge).
  function automatic exp_t model(input int t);
    exp_t        e;
    logic [15:0] d = '0;
    logic [3:0]  b = '0;
    logic [3:0]  p = '0;
    int          f, ph, dg, q, lc, nxt;
    e.sel  = 4'hF;
    e.dp_n = 1'b1;
    e.code = 4'h0;
    e.fs   = 1'b0;
    e.pend = 1'b0;
    if (loads.size() > 0) begin
      lc  = loads[loads.size()-1].c;
      // first boundary edge (end of cycle BL-1+k*FRAME) after the load edge
      nxt = BL - 1;
      while (nxt <= lc) nxt += FRAME;
      e.pend = (lc <= t - 1) && (nxt > t - 1);
    end
    if (t < BL) return e;
    f  = (t - BL) / FRAME;
    ph = (t - BL) % FRAME;
    dg = ph / SLOT;
    q  = ph % SLOT;
    foreach (loads[i]) begin
      if (loads[i].c <= BL - 2 + f * FRAME) begin
        d = loads[i].d;
        b = loads[i].b;
        p = loads[i].p;
      end
    end
    if (q < PS) begin
      e.code = d[dg*4 +: 4];
      if (!b[dg]) begin
        e.sel  = ~(4'b0001 << dg);
        e.dp_n = ~p[dg];
      end
    end else begin
      e.code = d[((dg + 1) % ND) * 4 +: 4];
    end
    e.fs = (ph == 0);
    return e;
  endfunction

  task automatic do_load(input logic [15:0] d, input logic [3:0] b, input logic [3:0] p);
    load      = 1'b1;
    digits_in = d;
    blank_in  = b;
    dp_in     = p;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur_e = sb.pop_front();
      check_eq("digit_sel_n", 16'(digit_sel_n), 16'(cur_e.sel));
      check_eq("dp_n",        16'(dp_n),        16'(cur_e.dp_n));
      check_eq("digit_code",  16'(digit_code),  16'(cur_e.code));
      check_eq("pending",     16'(pending),     16'(cur_e.pend));
      check_eq("frame_start", 16'(frame_start), 16'(cur_e.fs));
    end
  end

  initial begin
    load_t ld;
    int    t;
    int    ep;
    logic  rst_prev;
    rst       = 1'b1;
    load      = 1'b0;
    digits_in = '0;
    blank_in  = '0;
    dp_in     = '0;
    rst_prev  = 1'b1;
    t         = 0;
    ep        = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst_prev) begin
        t = 0;
        loads.delete();
      end else begin
        t++;
      end
      sb.push_back(model(t));
      load = 1'b0;
      rst  = 1'b0;
      if (cyc < 2) begin
        rst = 1'b1;
      end else begin
        case (ep)
          0: begin
            if (t == 0)  do_load(16'h4321, 4'b0000, 4'b0010);
            if (t == 10) do_load(16'h9999, 4'b0000, 4'b0000);
            if (t == 25) do_load(16'h5555, 4'b1000, 4'b0001);
            if (t == 80) begin
              rst = 1'b1;
              ep  = 1;
            end
          end
          1: begin
            if (t == 3) do_load(16'h8765, 4'b0000, 4'b1111);
            if (t == 15) begin
              rst = 1'b1;
              ep  = 2;
            end
          end
          default: ;
        endcase
      end
      if (load && !rst) begin
        ld.c = t;
        ld.d = digits_in;
        ld.b = blank_in;
        ld.p = dp_in;
        loads.push_back(ld);
      end
      rst_prev = rst;
    end
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) check_eq("drain", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Upstream stage of the 7-segment decoder: time-multiplexes NUM_DIGITS digit codes onto a single decoder input and drives the active-low common digit enables.
- Double-buffers the displayed value: a new value loads into a shadow register and is applied only at a frame boundary, so the display never shows a mix of old and new digits.
- Inserts a blanking gap between digits to suppress ghosting.
- Sits between the counter/datapath logic and the segment decoder on the board top level.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (>=2).
- CODE_W, 4, width of one digit code fed to the decoder.
- PRESCALE, 50000, clock cycles each digit is lit (>=1); 1 kHz per digit at 50 MHz.
- BLANK_CYCLES, 500, clock cycles all digits are off between digits (0 = no gap).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- load  in  1  strobe: capture digits_in/blank_in/dp_in into the shadow registers.
- digits_in  in  NUM_DIGITS*CODE_W  digit i = bits [i*CODE_W +: CODE_W]; digit 0 is rightmost.
- blank_in  in  NUM_DIGITS  1 = digit i stays dark.
- dp_in  in  NUM_DIGITS  1 = decimal point of digit i lit.
- digit_code  out  CODE_W  code of the current digit, to the decoder.
- digit_sel_n  out  NUM_DIGITS  active-low one-hot digit enable.
- dp_n  out  1  active-low decimal point for the current digit.
- pending  out  1  shadow holds a value not yet applied.
- frame_start  out  1  one-cycle pulse when digit 0 is lit at the start of a frame.

Behaviour:
- Registers: state {GAP, SHOW}, idx (0..NUM_DIGITS-1), cnt, shadow set, active set, pending, frame_start.
- Reset values (next edge with rst=1): state=GAP, idx=0, cnt=0, shadow/active all 0, pending=0, frame_start=0.
  - Resulting outputs: digit_sel_n all 1, dp_n=1, digit_code=0.
- Outputs decode from registers only, with no extra latency:
  - digit_sel_n[i]=0 iff state==SHOW, idx==i and active blank[i]==0.
  - digit_code = active digit[idx].
  - dp_n = ~(state==SHOW & active dp[idx] & ~active blank[idx]).
- GAP: cnt counts 0..BLANK_CYCLES-1. On the last cycle: cnt<=0, state<=SHOW.
- SHOW: cnt counts 0..PRESCALE-1. On the last cycle: cnt<=0, idx<=idx+1 (wraps NUM_DIGITS-1 -> 0).
  - BLANK_CYCLES>0: state<=GAP.
  - BLANK_CYCLES==0: stay in SHOW with the new idx. This is also an entry into SHOW.
- Frame boundary: any edge that enters SHOW with idx==0 (including after reset).
  - On that edge: frame_start<=1 (0 on all other edges).
  - If pending==1: active<=shadow and pending<=0.
- Load:
  - load=1 on any edge: shadow<=inputs and pending<=1. Always accepted; no back-pressure.
  - Load while pending: last load wins; the earlier value is never shown.
  - Load coincident with a frame boundary: the boundary applies the old shadow. The new value is captured and pending stays 1, so it applies at the next frame.
- Frame period = NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles.
- Reset mid-frame: everything returns to reset values; a pending load is discarded.
- cnt width = $clog2(max(PRESCALE,BLANK_CYCLES,2)); no overflow beyond the compare values.

Decomposition:
- Shared package display_pkg:
  - state enum {GAP, SHOW}.
  - default CODE_W=4.
  - code constants shared with the decoder (CODE_DASH=4'b1010, CODE_DOT=4'b1011).
- One natural sub-module, scan_timer: cnt plus state plus idx sequencing, emitting an "enter SHOW" strobe and idx.
- display_scan_mux keeps the shadow/active registers and output decode.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2; cycle 0 is the first cycle after rst drops.
- Reset: hold rst 3 cycles -> digit_sel_n=4'b1111, dp_n=1, pending=0, frame_start=0 throughout.
- Load at cycle 0 with digits_in=16'h4321, blank_in=0, dp_in=4'b0010:
  - pending=1 in cycle 1 only.
  - Cycle 2: frame_start=1, digit_sel_n=4'b1110, digit_code=1, dp_n=1.
  - Cycles 8-11: digit_sel_n=4'b1101, digit_code=2, dp_n=0.
- Scan timing: cycles 6-7 digit_sel_n=4'b1111; next frame_start at cycle 26; 24-cycle period repeats.
- Blank mask: load blank_in=4'b1000 -> digit 3 slot (cycles 20-23) keeps digit_sel_n=4'b1111 and dp_n=1.
- Mid-frame load: load 16'h9999 at cycle 10 -> digits 1-3 of the current frame still show 2,3,4; the new value appears from cycle 26.
  - Load 16'h5555 at cycle 25 (coincides with the boundary edge) -> frame at 26 shows 9999; 5555 from cycle 50.
- Reset mid-frame: pending load, then rst high at cycle 15 -> next cycle all outputs at reset values, pending=0, and the shadow value is never displayed.
